// File: rtl/udp_rx_capture.sv
// rtl/udp_rx_capture.sv - MII receive UDP payload filter and 32-bit RAM word packer
module udp_rx_capture #(
  parameter int          ADDR_W    = 9,
  parameter int          MAX_WORDS = 376,
  parameter logic [15:0] UDP_PORT  = 16'd5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [3:0]        rxd,
  input  logic              rx_er,
  input  logic              arm,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_ena,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [15:0]       byte_count
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_PRE, S_HDR, S_PAY, S_SKIP, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_WORDS);
  localparam logic [15:0]       WORD_MAX = 16'(MAX_WORDS);

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [3:0]        lo_nib_q, lo_nib_d;
  logic [5:0]        hdr_cnt_q, hdr_cnt_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              wr_ena_q, wr_ena_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       byte_count_q, byte_count_d;

  logic              byte_vld;
  logic [7:0]        rx_byte;

  // A byte completes on the second nibble of each rx_dv-aligned pair.
  always_comb begin
    byte_vld = rx_dv & phase_q;
    rx_byte  = {rxd, lo_nib_q};
    phase_d  = rx_dv ? ~phase_q : 1'b0;
    lo_nib_d = (rx_dv && !phase_q) ? rxd : lo_nib_q;
  end

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    len_hi_d     = len_hi_q;
    remaining_d  = remaining_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_ena_d     = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    ovf_d        = ovf_q;
    byte_count_d = byte_count_q;

    if (wr_ena_q && wr_addr_q != ADDR_MAX) wr_addr_d = wr_addr_q + 1'b1;

    if (!arm) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_GAP;
          done_d       = 1'b0;
          err_d        = 1'b0;
          ovf_d        = 1'b0;
          byte_count_d = 16'd0;
          wr_addr_d    = '0;
        end
        S_GAP: if (!rx_dv) state_d = S_PRE;
        S_PRE: begin
          if (byte_vld) begin
            if (rx_byte == 8'hD5) begin
              state_d   = S_HDR;
              hdr_cnt_d = 6'd0;
            end else if (rx_byte != 8'h55) begin
              state_d = S_SKIP;
            end
          end
        end
        S_HDR: begin
          if (!rx_dv || rx_er) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (byte_vld) begin
            hdr_cnt_d = hdr_cnt_q + 6'd1;
            case (hdr_cnt_q)
              6'd12: if (rx_byte != 8'h08) state_d = S_SKIP;
              6'd13: if (rx_byte != 8'h00) state_d = S_SKIP;
              6'd14: if (rx_byte != 8'h45) state_d = S_SKIP;
              6'd23: if (rx_byte != 8'h11) state_d = S_SKIP;
              6'd36: if (rx_byte != UDP_PORT[15:8]) state_d = S_SKIP;
              6'd37: if (rx_byte != UDP_PORT[7:0]) state_d = S_SKIP;
              6'd38: len_hi_d = rx_byte;
              6'd39: begin
                if ({len_hi_q, rx_byte} < 16'd8) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
                end else begin
                  remaining_d = {len_hi_q, rx_byte} - 16'd8;
                end
              end
              6'd41: begin
                byte_idx_d = 2'd0;
                word_cnt_d = 16'd0;
                state_d    = (remaining_q == 16'd0) ? S_DONE : S_PAY;
              end
              default: ;
            endcase
          end
        end
        S_PAY: begin
          if (word_cnt_q == WORD_MAX) begin
            // Overflow: drain the rest of the declared payload without storing it.
            if (!rx_dv) begin
              state_d = S_DONE;
            end else if (rx_er) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else if (byte_vld) begin
              remaining_d = remaining_q - 16'd1;
              if (remaining_q == 16'd1) state_d = S_DONE;
            end
          end else if (!rx_dv || rx_er) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (byte_vld) begin
            remaining_d  = remaining_q - 16'd1;
            byte_count_d = byte_count_q + 16'd1;
            byte_idx_d   = byte_idx_q + 2'd1;
            word_d       = (byte_idx_q == 2'd0) ? {24'd0, rx_byte}
                           : (word_q | ({24'd0, rx_byte} << {byte_idx_q, 3'b000}));
            if (byte_idx_q == 2'd3 || remaining_q == 16'd1) begin
              wr_ena_d   = 1'b1;
              wr_data_d  = word_d;
              word_cnt_d = word_cnt_q + 16'd1;
            end
            if (remaining_q == 16'd1) begin
              state_d = S_DONE;
            end else if (byte_idx_q == 2'd3 && word_cnt_q + 16'd1 == WORD_MAX) begin
              ovf_d = 1'b1;
            end
          end
        end
        S_SKIP: if (!rx_dv) state_d = S_PRE;
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      lo_nib_q     <= 4'd0;
      hdr_cnt_q    <= 6'd0;
      len_hi_q     <= 8'd0;
      remaining_q  <= 16'd0;
      word_q       <= 32'd0;
      byte_idx_q   <= 2'd0;
      word_cnt_q   <= 16'd0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      wr_ena_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      byte_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      lo_nib_q     <= lo_nib_d;
      hdr_cnt_q    <= hdr_cnt_d;
      len_hi_q     <= len_hi_d;
      remaining_q  <= remaining_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_ena_q     <= wr_ena_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_ena     = wr_ena_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ovf        = ovf_q;
  assign byte_count = byte_count_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_udp_rx_capture.sv
// tb/tb_udp_rx_capture.sv - scoreboard bench for udp_rx_capture with a frame-level reference model
module tb_udp_rx_capture;

  localparam int ADDR_W = 9;
  localparam int MAXW   = 4;
  localparam int CAP    = 4 * MAXW;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_dv;
  logic [3:0]        rxd;
  logic              rx_er;
  logic              arm;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ena;
  logic              busy;
  logic              done;
  logic              err;
  logic              ovf;
  logic [15:0]       byte_count;

  int total = 0;
  int bad   = 0;

  logic [7:0]  pay [$];
  int          exp_a [$];
  logic [31:0] exp_d [$];
  bit          ignore_wr = 1'b0;
  bit          exp_done, exp_err, exp_ovf;
  int          exp_bc;

  udp_rx_capture #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .UDP_PORT(16'd5000)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rxd(rxd), .rx_er(rx_er), .arm(arm),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ena(wr_ena), .busy(busy),
    .done(done), .err(err), .ovf(ovf), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_ena && !ignore_wr) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual addr=%0d data=%h expected none", wr_addr, wr_data);
      end else begin
        check("wr_addr", 32'(wr_addr), 32'(exp_a.pop_front()));
        check("wr_data", wr_data, exp_d.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = 4'd0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit er);
    rx_dv = 1'b1;
    rxd   = b[3:0];
    rx_er = er;
    @(posedge clk);
    #1;
    rxd   = b[7:4];
    rx_er = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    pay.delete();
    repeat (n) pay.push_back(8'($urandom));
  endtask

  task automatic send_frame(input logic [15:0] port, input logic [7:0] et_hi, input logic [7:0] proto,
                            input logic [15:0] len, input int n_send, input int er_at, input bit with_fcs);
    logic [7:0] h [42];
    for (int i = 0; i < 42; i++) h[i] = 8'($urandom);
    h[12] = et_hi;
    h[13] = 8'h00;
    h[14] = 8'h45;
    h[23] = proto;
    h[36] = port[15:8];
    h[37] = port[7:0];
    h[38] = len[15:8];
    h[39] = len[7:0];
    repeat (7) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < 42; i++) send_byte(h[i], 1'b0);
    for (int i = 0; i < n_send; i++) send_byte(pay[i], i == er_at);
    if (with_fcs) repeat (4) send_byte(8'($urandom), 1'b0);
    idle(12);
  endtask

  // Expected outcome of one capture from the payload bytes, declared length and failure point.
  task automatic predict(input bit hdr_ok, input int len, input int abort_at);
    int n, stored, words;
    logic [31:0] w;
    exp_done = hdr_ok;
    exp_err  = 1'b0;
    exp_ovf  = 1'b0;
    exp_bc   = 0;
    if (!hdr_ok) return;
    if (len < 8) begin
      exp_err = 1'b1;
      return;
    end
    n = len - 8;
    if (abort_at >= 0 && abort_at < n && abort_at < CAP) begin
      stored  = abort_at;
      exp_err = 1'b1;
      words   = stored / 4;
    end else begin
      stored  = (n < CAP) ? n : CAP;
      exp_ovf = (n > CAP);
      words   = (stored + 3) / 4;
    end
    exp_bc = stored;
    for (int k = 0; k < words; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < stored) w = w | (32'(pay[4 * k + b]) << (8 * b));
      exp_a.push_back(k);
      exp_d.push_back(w);
    end
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_busy"}, 32'(busy), 32'(!exp_done));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_byte_count"}, 32'(byte_count), 32'(exp_bc));
    check({tag, "_pending_writes"}, 32'(exp_a.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_wr_ena"}, 32'(wr_ena), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
  endtask

  task automatic arm_on();
    arm = 1'b1;
    idle(4);
  endtask

  task automatic arm_off();
    arm = 1'b0;
    idle(3);
  endtask

  initial begin
    rst   = 1'b1;
    arm   = 1'b0;
    rx_dv = 1'b0;
    rxd   = 4'd0;
    rx_er = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    arm_on();
    predict(1'b1, 14, -1);
    send_frame(16'd5000, 8'h08, 8'h11, 16'd14, 6, -1, 1'b1);
    check_status("good14");
    arm_off();

    arm_on();
    fill_rand(4);
    predict(1'b0, 12, -1);
    send_frame(16'd5001, 8'h08, 8'h11, 16'd12, 4, -1, 1'b1);
    check_status("port5001");
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    predict(1'b1, 12, -1);
    send_frame(16'd5000, 8'h08, 8'h11, 16'd12, 4, -1, 1'b1);
    check_status("after_filter");
    arm_off();

    arm_on();
    fill_rand(20);
    predict(1'b1, 28, -1);
    send_frame(16'd5000, 8'h08, 8'h11, 16'd28, 20, -1, 1'b1);
    check_status("overflow");
    arm_off();

    arm_on();
    fill_rand(CAP);
    predict(1'b1, CAP + 8, -1);
    send_frame(16'd5000, 8'h08, 8'h11, 16'(CAP + 8), CAP, -1, 1'b1);
    check_status("exact_cap");
    arm_off();

    arm_on();
    fill_rand(8);
    predict(1'b1, 16, 4);
    send_frame(16'd5000, 8'h08, 8'h11, 16'd16, 8, 4, 1'b1);
    check_status("rx_er");
    arm_off();

    fill_rand(10);
    fork
      send_frame(16'd5000, 8'h08, 8'h11, 16'd18, 10, -1, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #1;
        arm = 1'b1;
      end
    join
    fill_rand(7);
    predict(1'b1, 15, -1);
    send_frame(16'd5000, 8'h08, 8'h11, 16'd15, 7, -1, 1'b1);
    check_status("arm_midframe");
    arm_off();

    arm_on();
    fill_rand(12);
    ignore_wr = 1'b1;
    fork
      send_frame(16'd5000, 8'h08, 8'h11, 16'd20, 12, -1, 1'b1);
      begin
        repeat (118) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        arm = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ignore_wr = 1'b0;
      end
    join
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_byte_count", 32'(byte_count), 32'd0);
    idle(1);
    arm_on();
    fill_rand(9);
    predict(1'b1, 17, -1);
    send_frame(16'd5000, 8'h08, 8'h11, 16'd17, 9, -1, 1'b1);
    check_status("after_rst");
    arm_off();

    for (int it = 0; it < 30; it++) begin
      int n, r, ln, ab, kind, lim;
      n = $urandom_range(0, 30);
      r = $urandom_range(0, 99);
      fill_rand(n);
      arm_on();
      if (r < 12) begin
        kind = $urandom_range(0, 2);
        predict(1'b0, n + 8, -1);
        send_frame((kind == 0) ? 16'd5001 : 16'd5000, (kind == 1) ? 8'h86 : 8'h08,
                   (kind == 2) ? 8'h06 : 8'h11, 16'(n + 8), n, -1, 1'b1);
      end else if (r < 20) begin
        ln = $urandom_range(0, 7);
        predict(1'b1, ln, -1);
        send_frame(16'd5000, 8'h08, 8'h11, 16'(ln), n, -1, 1'b1);
      end else if (r < 40) begin
        if (n == 0) begin
          n = 5;
          fill_rand(n);
        end
        lim = (n < CAP) ? n : CAP;
        ab  = $urandom_range(0, lim - 1);
        predict(1'b1, n + 8, ab);
        send_frame(16'd5000, 8'h08, 8'h11, 16'(n + 8), n, ab, 1'b1);
      end else if (r < 55 && n > 0) begin
        ab = $urandom_range(0, n - 1);
        predict(1'b1, n + 8, ab);
        send_frame(16'd5000, 8'h08, 8'h11, 16'(n + 8), ab, -1, 1'b0);
      end else begin
        predict(1'b1, n + 8, -1);
        send_frame(16'd5000, 8'h08, 8'h11, 16'(n + 8), n, -1, 1'b1);
      end
      check_status("random");
      arm_off();
    end

    check("final_pending_writes", 32'(exp_a.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_capture.md
Name: udp_rx_capture

Overview:
- Upstream stage of the block-RAM capture path.
- Consumes the MII receive nibble stream, locks to the SFD and parses the Ethernet/IPv4/UDP headers.
- Filters frames on UDP destination port and packs the UDP payload into 32-bit words with a RAM write port (addr/data/ena).
- Replaces raw nibble dumping, so RAM holds only audio payload for UART dump and I2S playback.

Parameters:
ADDR_W, 9, RAM word-address width.
MAX_WORDS, 376, maximum words written per capture; excess payload is dropped.
UDP_PORT, 16'd5000, UDP destination port to accept.

Ports:
clk  in  1  eth_rx_clk domain; one nibble per cycle when rx_dv=1.
rst  in  1  asynchronous, active-high reset.
rx_dv  in  1  MII receive data valid.
rxd  in  4  MII receive nibble; low nibble of each byte arrives first.
rx_er  in  1  MII receive error.
arm  in  1  level; 1 = capture next matching frame; 0 = return to idle.
wr_addr  out  ADDR_W  RAM word address.
wr_data  out  32  packed payload word.
wr_ena  out  1  one-cycle write strobe.
busy  out  1  armed and capture not finished.
done  out  1  capture finished; sticky until arm falls.
err  out  1  capture ended abnormally; sticky until arm falls.
ovf  out  1  payload exceeded MAX_WORDS*4 bytes; sticky until arm falls.
byte_count  out  16  payload bytes actually stored.

Behaviour:
- Reset (async) values: state=S_IDLE; all outputs 0; nibble phase 0.
- Byte assembly: byte={second nibble, first nibble}. Phase toggles on each rx_dv=1 cycle. Phase clears whenever rx_dv=0.
- S_IDLE: outputs held. When arm=1, clear done/err/ovf/byte_count/wr_addr, then go to S_GAP.
- S_GAP: wait for one cycle with rx_dv=0, so capture never starts mid-frame. Then go to S_PRE.
- S_PRE: accept bytes 0x55. On byte 0xD5, set hdr_cnt=0 and go to S_HDR. Any other byte goes to S_SKIP. rx_dv=0 stays in S_PRE.
- S_HDR: 42 header bytes at offsets 0..41.
  - Required fields: offset 12-13 = 0x08,0x00; offset 14 = 0x45; offset 23 = 0x11; offset 36-37 = UDP_PORT, big-endian.
  - Offset 38-39 is the UDP length L, big-endian.
  - Any field mismatch goes to S_SKIP. This is a silent filter: no err.
  - L<8 sets err and goes to S_DONE.
  - After offset 41, set remaining=L-8. If remaining=0, go to S_DONE; else go to S_PAY.
- S_PAY:
  - Pack bytes little-endian: first byte goes to wr_data[7:0], fourth to [31:24].
  - Each byte decrements remaining and increments byte_count, but only while the word count is below MAX_WORDS.
  - When the 4th byte of a word is complete, wr_ena=1 on the next cycle with the current wr_addr. wr_addr increments the cycle after the strobe.
  - When remaining reaches 0 with a partial word, that word is written zero-padded in the upper bytes on the next cycle. Then go to S_DONE.
  - When MAX_WORDS words have been written and remaining>0: set ovf=1. Discard further payload, with no writes and no byte_count increment. Go to S_DONE when remaining reaches 0 or rx_dv falls.
  - FCS and Ethernet padding after the payload are ignored.
- S_SKIP: wait for rx_dv=0, then go to S_PRE. The block stays armed.
- Abnormal termination in S_HDR/S_PAY:
  - rx_er=1 during rx_dv sets err=1 and goes to S_DONE; the in-progress partial word is not written.
  - rx_dv falling before remaining=0 (truncated frame) has the same result.
- S_DONE: done=1, busy=0. On arm=0 go to S_IDLE; outputs hold until then.
- busy=1 in S_GAP, S_PRE, S_HDR, S_PAY and S_SKIP.
- arm=0 in any state returns to S_IDLE on the next cycle. Writes already issued stand; there is no flush of a partial word.
- wr_ena never asserts outside S_PAY or the flush cycle. At most one write per 8 cycles at full rate, so no back-pressure exists.
- wr_addr saturates at MAX_WORDS (no wrap) and never exceeds MAX_WORDS-1 when wr_ena=1.

Test Plan:
- Good frame, port 5000, L=14, payload 01..06 -> writes 0x04030201 @0 and 0x00000605 @1. Then done=1, byte_count=6, err=0, ovf=0.
- Frame with port 5001, then a good frame with L=12 payload AA BB CC DD -> first frame causes no writes and busy stays 1. Second frame gives one write 0xDDCCBBAA @0 and done=1.
- MAX_WORDS=2, L=20 (12 payload bytes) -> writes @0 and @1 only. byte_count=8, ovf=1, done=1.
- rx_er pulse at payload byte 5 of a 8-byte payload -> one write @0, err=1, done=1. No write @1.
- arm raised while rx_dv=1 mid-frame -> that frame is ignored through S_GAP. The following good frame is captured.
- Async rst asserted during S_PAY -> all outputs 0 immediately. No wr_ena after release until re-armed and a new frame arrives.
